sgmii_pcs_tx: RTL



---
 rtl/sgmii_pcs_tx.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sgmii_pcs_tx.sv
// sgmii_pcs_tx: 1000BASE-X / SGMII PCS transmit ordered-set generator.
// Turns the GMII TX byte stream into 8-bit code groups plus a K flag. The
// transceiver does the 8b10b encoding. This block inserts /I/, /S/, /T/,
// /R/ and /V/ and keeps every ordered set aligned to an even slot.
//
// Optional build macro: SGMII_TX_CONFIG_EN (adds /C1/ /C2/ generation).
//
// Ports:
//   i_Clk              125 MHz TX code-group clock
//   i_ARst             asynchronous reset, active-high
//   i8_GmiiTxd         GMII transmit data
//   i_GmiiTxEn         GMII transmit enable
//   i_GmiiTxEr         GMII transmit error
//   i_RunningDisparity transceiver running disparity (1 = positive)
//   i_TxConfig         (macro only) xmit = CONFIGURATION
//   i16_ConfigReg      (macro only) config word sent in /C/ sets
//   o8_TxCodeGroup     code group to the transceiver
//   o_TxCodeCtrl       1 = K code group
//   o_TxCodeValid      code group valid
//   o_TxForceNegDisp   force negative disparity on this code group
//   o_TxEven           1 = current output slot is even
module sgmii_pcs_tx #(
   parameter int pI1Enable = 1,
   parameter int pIdleCnt  = 1
) (
   input  logic        i_Clk,
   input  logic        i_ARst,
   input  logic [7:0]  i8_GmiiTxd,
   input  logic        i_GmiiTxEn,
   input  logic        i_GmiiTxEr,
   input  logic        i_RunningDisparity,
`ifdef SGMII_TX_CONFIG_EN
   input  logic        i_TxConfig,
   input  logic [15:0] i16_ConfigReg,
`endif
   output logic [7:0]  o8_TxCodeGroup,
   output logic        o_TxCodeCtrl,
   output logic        o_TxCodeValid,
   output logic        o_TxForceNegDisp,
   output logic        o_TxEven
);

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] D5_6  = 8'hC5;
   localparam logic [7:0] D16_2 = 8'h50;
   localparam logic [7:0] K_S   = 8'hFB;
   localparam logic [7:0] K_T   = 8'hFD;
   localparam logic [7:0] K_R   = 8'hF7;
   localparam logic [7:0] K_V   = 8'hFE;
`ifdef SGMII_TX_CONFIG_EN
   localparam logic [7:0] D21_5 = 8'hB5;
   localparam logic [7:0] D2_2  = 8'h42;
`endif

   localparam logic [2:0] IDLE_MIN = 3'(pIdleCnt);

   typedef enum logic [2:0] {
      IDLE_K,
      IDLE_D,
      DATA,
      EPD_R,
      EPD_R2,
      CFG_D,
      CFG_LO,
      CFG_HI
   } state_t;

   state_t     state;
   state_t     stateNext;
   logic       slotEven;
   logic       bootSlot;
   logic       firstIdle;
   logic       firstIdleNext;
   logic [2:0] idleSets;
   logic [2:0] idleSetsNext;
   logic [7:0] codeNext;
   logic       ctrlNext;
   logic       cfgReq;
   logic       startOk;

`ifdef SGMII_TX_CONFIG_EN
   logic        cfgAlt;
   logic [15:0] cfgReg;

   assign cfgReq = i_TxConfig;

   // Config word is latched with the K28.5 so a set never mixes two words;
   // cfgAlt picks /C1/ or /C2/ and flips after each completed set.
   always_ff @(posedge i_Clk or posedge i_ARst) begin
      if (i_ARst) begin
         cfgAlt <= 1'b0;
         cfgReg <= 16'h0000;
      end else begin
         if (state == IDLE_K && cfgReq)
            cfgReg <= i16_ConfigReg;
         if (state == CFG_HI)
            cfgAlt <= ~cfgAlt;
      end
   end
`else
   assign cfgReq = 1'b0;
`endif

   // A packet may only open on an even slot, once enough /I/ sets have gone
   // out; until then preamble bytes are silently dropped.
   assign startOk = i_GmiiTxEn && !cfgReq && (idleSets >= IDLE_MIN);

   // State register, bookkeeping and registered outputs
   always_ff @(posedge i_Clk or posedge i_ARst) begin
      if (i_ARst) begin
         state            <= IDLE_K;
         slotEven         <= 1'b1;
         bootSlot         <= 1'b1;
         firstIdle        <= 1'b1;
         idleSets         <= 3'd0;
         o8_TxCodeGroup   <= K28_5;
         o_TxCodeCtrl     <= 1'b1;
         o_TxCodeValid    <= 1'b0;
         o_TxForceNegDisp <= 1'b0;
         o_TxEven         <= 1'b1;
      end else begin
         state            <= stateNext;
         slotEven         <= ~slotEven;
         bootSlot         <= 1'b0;
         firstIdle        <= firstIdleNext;
         idleSets         <= idleSetsNext;
         o8_TxCodeGroup   <= codeNext;
         o_TxCodeCtrl     <= ctrlNext;
         o_TxCodeValid    <= 1'b1;
         o_TxForceNegDisp <= bootSlot;
         o_TxEven         <= slotEven;
      end
   end

   // Next-state logic
   always_comb begin
      stateNext     = state;
      idleSetsNext  = idleSets;
      firstIdleNext = firstIdle;
      unique case (state)
         IDLE_K: begin
            if (cfgReq) begin
               stateNext = CFG_D;
            end else if (startOk) begin
               stateNext     = DATA;
               idleSetsNext  = 3'd0;
               firstIdleNext = 1'b1;
            end else begin
               stateNext = IDLE_D;
            end
         end
         IDLE_D: begin
            stateNext     = IDLE_K;
            firstIdleNext = 1'b0;
            if (idleSets < IDLE_MIN)
               idleSetsNext = idleSets + 3'd1;
         end
         DATA: begin
            if (!i_GmiiTxEn)
               stateNext = EPD_R;
         end
         // A /R/ on an even slot needs a second /R/ to realign.
         EPD_R: begin
            stateNext = slotEven ? EPD_R2 : IDLE_K;
         end
         EPD_R2: begin
            stateNext = IDLE_K;
         end
`ifdef SGMII_TX_CONFIG_EN
         CFG_D: begin
            stateNext = CFG_LO;
         end
         CFG_LO: begin
            stateNext = CFG_HI;
         end
         CFG_HI: begin
            stateNext = IDLE_K;
         end
`endif
         default: begin
            stateNext = IDLE_K;
         end
      endcase
   end

   // Output logic (code group for the slot being registered)
   always_comb begin
      codeNext = K28_5;
      ctrlNext = 1'b1;
      unique case (state)
         IDLE_K: begin
            if (startOk)
               codeNext = K_S;
            else
               codeNext = K28_5;
            ctrlNext = 1'b1;
         end
         // /I1/ flips a positive disparity back to negative.
         IDLE_D: begin
            if (firstIdle && (pI1Enable != 0) && i_RunningDisparity)
               codeNext = D5_6;
            else
               codeNext = D16_2;
            ctrlNext = 1'b0;
         end
         DATA: begin
            if (!i_GmiiTxEn) begin
               codeNext = K_T;
               ctrlNext = 1'b1;
            end else if (i_GmiiTxEr) begin
               codeNext = K_V;
               ctrlNext = 1'b1;
            end else begin
               codeNext = i8_GmiiTxd;
               ctrlNext = 1'b0;
            end
         end
         EPD_R, EPD_R2: begin
            codeNext = K_R;
            ctrlNext = 1'b1;
         end
`ifdef SGMII_TX_CONFIG_EN
         CFG_D: begin
            codeNext = cfgAlt ? D2_2 : D21_5;
            ctrlNext = 1'b0;
         end
         CFG_LO: begin
            codeNext = cfgReg[7:0];
            ctrlNext = 1'b0;
         end
         CFG_HI: begin
            codeNext = cfgReg[15:8];
            ctrlNext = 1'b0;
         end
`endif
         default: begin
            codeNext = K28_5;
            ctrlNext = 1'b1;
         end
      endcase
   end

endmodule
